// File: rtl/acc_requant8_if.sv
// Stream bundle for acc_requant8: accumulator input channel and INT8 result channel.
// The design takes the slave view; the producer/consumer side takes the master view.
interface acc_requant8_if #(
  parameter int ACC_W = 32
);
  logic signed [ACC_W-1:0] acc_in;
  logic                    acc_valid;
  logic                    acc_ready;
  logic signed [7:0]       q_out;
  logic                    q_valid;
  logic                    q_ready;

  modport master (
    output acc_in, acc_valid, q_ready,
    input  acc_ready, q_out, q_valid
  );

  modport slave (
    input  acc_in, acc_valid, q_ready,
    output acc_ready, q_out, q_valid
  );
endinterface

// File: rtl/acc_requant8.sv
// Requantizer: q = sat8(round((acc * M) >> SHIFT) + ZP), 3-stage valid/ready pipeline.
// Define ACC_REQUANT_RELU_EN to raise the lower clamp bound to the zero point (fused ReLU).
module acc_requant8 #(
  parameter int ACC_W = 32,
  parameter int M_W   = 16,
  parameter int SH_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  acc_requant8_if.slave        bus,
  input  logic                 cfg_we,
  input  logic [M_W-1:0]       cfg_m,
  input  logic [SH_W-1:0]      cfg_shift,
  input  logic signed [7:0]    cfg_zp,
  output logic                 cfg_err,
  output logic [CNT_W-1:0]     sat_cnt,
  output logic                 busy
);
  localparam int P_W = ACC_W + M_W + 1;
  localparam int R_W = P_W + 1;
  localparam int Y_W = R_W + 1;
  localparam logic signed [Y_W-1:0] HI_Y  = Y_W'(127);
  localparam logic signed [Y_W-1:0] MIN_Y = -(Y_W'(128));
  localparam logic [SH_W-1:0]       SH_ONE = SH_W'(1);

  logic [M_W-1:0]          m_r;
  logic [SH_W-1:0]         sh_r;
  logic signed [7:0]       zp_r;
  logic                    v1_r, v2_r, v3_r;
  logic signed [P_W-1:0]   p_r;
  logic signed [R_W-1:0]   r_r;
  logic signed [7:0]       q_r;
  logic                    cfg_err_r;
  logic [CNT_W-1:0]        sat_cnt_r;

  logic                    adv_s, take_s, busy_s, cfg_ok_s;
  logic signed [P_W-1:0]   acc_ext_s, m_ext_s, p_s;
  logic signed [R_W-1:0]   rnd_s, sum_s, r_s;
  logic signed [Y_W-1:0]   y_s, lo_s;
  logic                    sat_s;
  logic signed [7:0]       q_s;

  // Handshake, config acceptance and the three datapath stages' combinational logic.
  always_comb begin
    adv_s     = !v3_r | bus.q_ready;
    take_s    = bus.acc_valid & adv_s;
    busy_s    = v1_r | v2_r | v3_r;
    cfg_ok_s  = cfg_we & !busy_s & !take_s;

    acc_ext_s = {{(P_W-ACC_W){bus.acc_in[ACC_W-1]}}, bus.acc_in};
    m_ext_s   = {{(P_W-M_W){1'b0}}, m_r};
    p_s       = acc_ext_s * m_ext_s;

    // One guard bit above the product keeps the rounding add from overflowing.
    if (sh_r == {SH_W{1'b0}}) begin
      rnd_s = {R_W{1'b0}};
    end else begin
      rnd_s = {{(R_W-1){1'b0}}, 1'b1} << (sh_r - SH_ONE);
    end
    sum_s = {p_r[P_W-1], p_r} + rnd_s;
    r_s   = sum_s >>> sh_r;

    y_s   = {r_r[R_W-1], r_r} + {{(Y_W-8){zp_r[7]}}, zp_r};
`ifdef ACC_REQUANT_RELU_EN
    lo_s  = {{(Y_W-8){zp_r[7]}}, zp_r};
`else
    lo_s  = MIN_Y;
`endif
    sat_s = (y_s > HI_Y) | (y_s < MIN_Y);
    if (y_s > HI_Y) begin
      q_s = 8'sd127;
    end else if (y_s < lo_s) begin
      q_s = lo_s[7:0];
    end else begin
      q_s = y_s[7:0];
    end
  end

  // Pipeline registers, configuration registers, error pulse and saturation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_r       <= {{(M_W-1){1'b0}}, 1'b1};
      sh_r      <= {SH_W{1'b0}};
      zp_r      <= 8'sd0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      v3_r      <= 1'b0;
      p_r       <= {P_W{1'b0}};
      r_r       <= {R_W{1'b0}};
      q_r       <= 8'sd0;
      cfg_err_r <= 1'b0;
      sat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      cfg_err_r <= cfg_we & !cfg_ok_s;
      if (cfg_ok_s) begin
        m_r  <= cfg_m;
        sh_r <= cfg_shift;
        zp_r <= cfg_zp;
      end
      if (adv_s) begin
        v1_r <= bus.acc_valid;
        v2_r <= v1_r;
        v3_r <= v2_r;
        if (bus.acc_valid) begin
          p_r <= p_s;
        end
        if (v1_r) begin
          r_r <= r_s;
        end
        if (v2_r) begin
          q_r <= q_s;
          if (sat_s && (sat_cnt_r != {CNT_W{1'b1}})) begin
            sat_cnt_r <= sat_cnt_r + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.acc_ready = adv_s;
  assign bus.q_out     = q_r;
  assign bus.q_valid   = v3_r;
  assign cfg_err       = cfg_err_r;
  assign sat_cnt       = sat_cnt_r;
  assign busy          = busy_s;
endmodule

// File: tb/tb_acc_requant8.sv
// Directed bench for acc_requant8: vector table plus backpressure, config and reset sequences.
module tb_acc_requant8;
  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [15:0]       cfg_m;
  logic [4:0]        cfg_shift;
  logic signed [7:0] cfg_zp;
  logic              cfg_err;
  logic [15:0]       sat_cnt;
  logic              busy;

  acc_requant8_if #(.ACC_W(32)) bus ();

  acc_requant8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_m     (cfg_m),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .cfg_err   (cfg_err),
    .sat_cnt   (sat_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]        m;
    logic [4:0]         sh;
    logic signed [7:0]  zp;
    logic signed [31:0] acc;
    logic signed [7:0]  q;
    int                 sat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [15:0] m, input logic [4:0] sh, input logic signed [7:0] zp);
    @(negedge clk);
    cfg_we = 1'b1; cfg_m = m; cfg_shift = sh; cfg_zp = zp;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_idle", cfg_err, 0);
  endtask

  // Send one value into an idle pipeline; report the result and its latency in cycles.
  task automatic send_one(input logic signed [31:0] a, output logic signed [7:0] q, output int lat);
    @(negedge clk);
    bus.acc_valid = 1'b1; bus.acc_in = a;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    lat = 1;
    while (!bus.q_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    q = bus.q_out;
  endtask

  task automatic wait_q(output logic signed [7:0] q);
    int k;
    k = 0;
    while (!bus.q_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("wait_q_timeout", k < 10, 1);
    q = bus.q_out;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[19];
    logic signed [7:0] q;
    logic signed [7:0] held;
    logic signed [7:0] rx[10];
    int lat, sat_exp, nxt, nrx, seen;
    logic stalled;

    vt[0]  = '{16'd16384, 5'd15, 8'sd0,   32'sd200,   8'sd100, 0};
    vt[1]  = '{16'd1,     5'd1,  8'sd0,   32'sd3,     8'sd2,   0};
    vt[2]  = '{16'd1,     5'd1,  8'sd0,  -32'sd3,    -8'sd1,   0};
    vt[3]  = '{16'd1,     5'd1,  8'sd0,   32'sd5,     8'sd3,   0};
    vt[4]  = '{16'd1,     5'd1,  8'sd0,  -32'sd5,    -8'sd2,   0};
    vt[5]  = '{16'd1,     5'd0,  8'sd0,  -32'sd7,    -8'sd7,   0};
    vt[6]  = '{16'd1,     5'd0,  8'sd5,   32'sd1000,  8'sd127, 1};
    vt[7]  = '{16'd1,     5'd0,  8'sd5,  -32'sd1000,  8'sh80,  1};
    vt[8]  = '{16'd1,     5'd0,  8'sd5,   32'sd122,   8'sd127, 0};
    vt[9]  = '{16'd1,     5'd0,  8'sd5,   32'sd123,   8'sd127, 1};
    vt[10] = '{16'd65535, 5'd31, 8'sd0,   32'sh8000_0000, 8'sh80, 1};
    vt[11] = '{16'd65535, 5'd31, 8'sd0,   32'sh7fff_ffff, 8'sd127, 1};
    vt[12] = '{16'd1,     5'd31, 8'sd0,   32'sh4000_0000, 8'sd1, 0};
    vt[13] = '{16'd1,     5'd31, 8'sd0,   32'sh3fff_ffff, 8'sd0, 0};
`ifdef ACC_REQUANT_RELU_EN
    vt[14] = '{16'd1,     5'd0, -8'sd10, -32'sd50,   -8'sd10,  0};
`else
    vt[14] = '{16'd1,     5'd0, -8'sd10, -32'sd50,   -8'sd60,  0};
`endif
    vt[15] = '{16'd1,     5'd0,  8'sh80, -32'sd1,     8'sh80,  1};
    vt[16] = '{16'd3,     5'd2,  8'sd0,  -32'sd6,    -8'sd4,   0};
    vt[17] = '{16'd1,     5'd2,  8'sd0,  -32'sd2,     8'sd0,   0};
    vt[18] = '{16'd1,     5'd0, -8'sd10,  32'sd50,    8'sd40,  0};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_m = 16'd0; cfg_shift = 5'd0; cfg_zp = 8'sd0;
    bus.acc_valid = 1'b0; bus.acc_in = 32'sd0; bus.q_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_q_valid", bus.q_valid, 0);
    check("rst_q_out", bus.q_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_acc_ready", bus.acc_ready, 1);

    // Vector table: configure while idle, send one value, check result, latency and sat count.
    sat_exp = 0;
    for (int i = 0; i < 19; i++) begin
      do_cfg(vt[i].m, vt[i].sh, vt[i].zp);
      send_one(vt[i].acc, q, lat);
      sat_exp += vt[i].sat;
      check($sformatf("vec%0d_q", i), q, vt[i].q);
      check($sformatf("vec%0d_latency", i), lat, 3);
      @(negedge clk);
      check($sformatf("vec%0d_sat_cnt", i), sat_cnt, sat_exp);
    end

    // Backpressure: stream 1..10, stall output for cycles 4..9, then random ready.
    do_cfg(16'd1, 5'd0, 8'sd0);
    nxt = 1; nrx = 0; stalled = 1'b0; held = 8'sd0;
    for (int i = 0; i < 10; i++) rx[i] = 8'sd0;
    for (int cyc = 0; cyc < 300 && nrx < 10; cyc++) begin
      @(negedge clk);
      if (cyc < 4) bus.q_ready = 1'b1;
      else if (cyc <= 9) bus.q_ready = 1'b0;
      else bus.q_ready = 1'($urandom_range(1, 0));
      #1;
      if (stalled) begin
        check("bp_stall_hold", bus.q_out, held);
        check("bp_stall_valid", bus.q_valid, 1);
      end
      if (bus.q_valid && !bus.q_ready) check("bp_acc_ready_blocked", bus.acc_ready, 0);
      if (bus.q_valid && bus.q_ready) begin
        rx[nrx] = bus.q_out;
        nrx++;
      end
      stalled = bus.q_valid & !bus.q_ready;
      held = bus.q_out;
      if (nxt <= 10) begin
        bus.acc_valid = 1'b1;
        bus.acc_in = nxt;
        if (bus.acc_ready) nxt++;
      end else begin
        bus.acc_valid = 1'b0;
      end
    end
    bus.acc_valid = 1'b0;
    bus.q_ready = 1'b1;
    check("bp_count", nrx, 10);
    for (int i = 0; i < 10; i++) check($sformatf("bp_rx%0d", i), rx[i], i + 1);
    repeat (4) @(negedge clk);

    // Config while busy is rejected and the in-flight value keeps the old M.
    do_cfg(16'd2, 5'd0, 8'sd0);
    @(negedge clk);
    bus.acc_valid = 1'b1; bus.acc_in = 32'sd10;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    cfg_we = 1'b1; cfg_m = 16'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_busy_err", cfg_err, 1);
    @(negedge clk);
    check("cfg_busy_err_pulse", cfg_err, 0);
    wait_q(q);
    check("cfg_busy_old_m", q, 20);
    repeat (3) @(negedge clk);
    do_cfg(16'd3, 5'd0, 8'sd0);
    send_one(32'sd10, q, lat);
    check("cfg_new_m", q, 30);
    do_cfg(16'd3, 5'd1, 8'sd4);
    send_one(32'sd10, q, lat);
    check("cfg_new_m_sh_zp", q, 19);
    repeat (3) @(negedge clk);

    // Config coinciding with an accepted input is rejected.
    @(negedge clk);
    bus.acc_valid = 1'b1; bus.acc_in = 32'sd10;
    cfg_we = 1'b1; cfg_m = 16'd5; cfg_shift = 5'd0; cfg_zp = 8'sd0;
    @(negedge clk);
    bus.acc_valid = 1'b0; cfg_we = 1'b0;
    check("cfg_coincide_err", cfg_err, 1);
    @(negedge clk);
    check("cfg_coincide_err_pulse", cfg_err, 0);
    wait_q(q);
    check("cfg_coincide_old_cfg", q, 19);
    repeat (3) @(negedge clk);

    // Reset with three values in flight and the output blocked.
    do_cfg(16'd1, 5'd0, 8'sd0);
    bus.q_ready = 1'b0;
    @(negedge clk); bus.acc_valid = 1'b1; bus.acc_in = 32'sd100;
    @(negedge clk); bus.acc_in = 32'sd1000;
    @(negedge clk); bus.acc_in = -32'sd1000;
    @(negedge clk);
    bus.acc_valid = 1'b0;
    check("rst_mid_full_busy", busy, 1);
    check("rst_mid_full_ready", bus.acc_ready, 0);
    check("rst_mid_sat_before", sat_cnt != 16'd0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.q_ready = 1'b1;
    check("rst_mid_q_valid", bus.q_valid, 0);
    check("rst_mid_sat_cnt", sat_cnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_q_out", bus.q_out, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.q_valid) seen++;
    end
    check("rst_mid_no_emit", seen, 0);
    send_one(32'sd42, q, lat);
    check("rst_default_cfg", q, 42);
    check("rst_default_latency", lat, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
